// File: rtl/frog_mover.sv
// Player-position controller for the 16x16 frogger playfield: turns key edges into
// single-step frog moves, and handles hits, respawn, lives, goal and game-over.
module frog_mover #(
    parameter int SPAWN_ROW     = 15,
    parameter int SPAWN_COL     = 8,
    parameter int LIVES         = 3,
    parameter int COOLDOWN      = 4,
    parameter int RESPAWN_DELAY = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_up,
    input  logic              key_down,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              hit,
    output logic [15:0][15:0] sprite_grid,
    output logic [3:0]        row,
    output logic [3:0]        col,
    output logic [2:0]        lives,
    output logic              goal,
    output logic              game_over
);

    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
    localparam int RD_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY + 1) : 1;

    localparam logic [3:0]      SPAWN_ROW_L = 4'(SPAWN_ROW);
    localparam logic [3:0]      SPAWN_COL_L = 4'(SPAWN_COL);
    localparam logic [2:0]      LIVES_L     = 3'(LIVES);
    localparam logic [CD_W-1:0] COOLDOWN_L  = CD_W'(COOLDOWN);
    localparam logic [RD_W-1:0] RESPAWN_L   = RD_W'(RESPAWN_DELAY);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_GOAL,
        ST_DEAD,
        ST_OVER
    } state_t;

    state_t          state_reg;
    logic [3:0]      row_reg;
    logic [3:0]      col_reg;
    logic [2:0]      lives_reg;
    logic            goal_reg;
    logic            over_reg;
    logic [CD_W-1:0] cd_reg;
    logic [RD_W-1:0] rc_reg;
    logic [3:0]      key_q_reg;

    logic [3:0]      keys;
    logic [3:0]      press;
    logic [3:0]      row_next;
    logic [3:0]      col_next;
    logic [2:0]      lives_dec;
    logic            move_ok;
    logic            reach_goal;

    // Key vector order matches move priority: up, down, left, right.
    assign keys  = {key_up, key_down, key_left, key_right};
    assign press = keys & ~key_q_reg;

    assign move_ok    = (press != 4'b0000) && (cd_reg == '0);
    assign reach_goal = press[3] && (row_reg == 4'd1);
    assign lives_dec  = (lives_reg != 3'd0) ? (lives_reg - 3'd1) : 3'd0;

    // Highest-priority press picks the step; edge cells hold position.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (press[3]) begin
            if (row_reg != 4'd0) begin
                row_next = row_reg - 4'd1;
            end
        end else if (press[2]) begin
            if (row_reg != 4'd15) begin
                row_next = row_reg + 4'd1;
            end
        end else if (press[1]) begin
            if (col_reg != 4'd15) begin
                col_next = col_reg + 4'd1;
            end
        end else if (press[0]) begin
            if (col_reg != 4'd0) begin
                col_next = col_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // Key history tracks levels even in reset so a held key cannot fire afterwards.
        key_q_reg <= keys;
        if (reset) begin
            state_reg <= ST_PLAY;
            row_reg   <= SPAWN_ROW_L;
            col_reg   <= SPAWN_COL_L;
            lives_reg <= LIVES_L;
            goal_reg  <= 1'b0;
            over_reg  <= 1'b0;
            cd_reg    <= '0;
            rc_reg    <= '0;
        end else begin
            goal_reg <= 1'b0;
            case (state_reg)
                ST_PLAY: begin
                    if (hit) begin
                        lives_reg <= lives_dec;
                        cd_reg    <= '0;
                        if (lives_reg <= 3'd1) begin
                            state_reg <= ST_OVER;
                            over_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_DEAD;
                            rc_reg    <= RESPAWN_L;
                        end
                    end else if (move_ok) begin
                        row_reg <= row_next;
                        col_reg <= col_next;
                        cd_reg  <= COOLDOWN_L;
                        if (reach_goal) begin
                            state_reg <= ST_GOAL;
                            goal_reg  <= 1'b1;
                        end
                    end else if (cd_reg != '0) begin
                        cd_reg <= cd_reg - CD_W'(1);
                    end
                end
                ST_GOAL: begin
                    state_reg <= ST_PLAY;
                    row_reg   <= SPAWN_ROW_L;
                    col_reg   <= SPAWN_COL_L;
                    cd_reg    <= '0;
                end
                ST_DEAD: begin
                    if (rc_reg == '0) begin
                        state_reg <= ST_PLAY;
                        row_reg   <= SPAWN_ROW_L;
                        col_reg   <= SPAWN_COL_L;
                        cd_reg    <= '0;
                    end else begin
                        rc_reg <= rc_reg - RD_W'(1);
                    end
                end
                ST_OVER: begin
                    over_reg <= 1'b1;
                end
            endcase
        end
    end

    logic        show;
    logic [15:0] row_hot;
    logic [15:0] col_hot;

    assign show = (state_reg == ST_PLAY) || (state_reg == ST_GOAL);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_sprite
            assign row_hot[gi]     = (row_reg == 4'(gi));
            assign col_hot[gi]     = (col_reg == 4'(gi));
            assign sprite_grid[gi] = (show && row_hot[gi]) ? col_hot : 16'h0000;
        end
    endgenerate

    assign row       = row_reg;
    assign col       = col_reg;
    assign lives     = lives_reg;
    assign goal      = goal_reg;
    assign game_over = over_reg;

endmodule

// File: tb/tb_frog_mover.sv
// Bench for frog_mover: directed vector table, hand-written corner sequences and a
// randomized run against a time-based reference model.
module tb_frog_mover;

    localparam int SR = 15;
    localparam int SC = 8;
    localparam int NL = 3;
    localparam int CD = 4;
    localparam int RD = 8;

    localparam logic [3:0] K_U = 4'b1000;
    localparam logic [3:0] K_D = 4'b0100;
    localparam logic [3:0] K_L = 4'b0010;
    localparam logic [3:0] K_R = 4'b0001;
    localparam logic [3:0] K_0 = 4'b0000;

    logic              clk = 1'b0;
    logic              reset;
    logic              key_up, key_down, key_left, key_right, hit;
    logic [15:0][15:0] sprite_grid;
    logic [3:0]        row, col;
    logic [2:0]        lives;
    logic              goal, game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frog_mover #(
        .SPAWN_ROW(SR), .SPAWN_COL(SC), .LIVES(NL), .COOLDOWN(CD), .RESPAWN_DELAY(RD)
    ) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .hit(hit), .sprite_grid(sprite_grid), .row(row), .col(col),
        .lives(lives), .goal(goal), .game_over(game_over)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0][15:0] grid_at(input bit vis, input int r, input int c);
        logic [15:0][15:0] g;
        g = '0;
        if (vis) g[r][c] = 1'b1;
        return g;
    endfunction

    task automatic chk_grid(input string name, input logic [15:0][15:0] exp);
        checks++;
        if (sprite_grid !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, sprite_grid, exp);
        end
    endtask

    task automatic expect_state(input string tag, input bit vis, input int r, input int c,
                                input int l, input bit g, input bit ov);
        chk_grid({tag, ".grid"}, grid_at(vis, r, c));
        if (vis) begin
            chk({tag, ".row"}, 32'(row), 32'(r));
            chk({tag, ".col"}, 32'(col), 32'(c));
        end
        chk({tag, ".lives"}, 32'(lives), 32'(l));
        chk({tag, ".goal"}, 32'(goal), 32'(g));
        chk({tag, ".game_over"}, 32'(game_over), 32'(ov));
    endtask

    task automatic set_in(input logic [3:0] k, input logic h);
        {key_up, key_down, key_left, key_right} = k;
        hit = h;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] k);
        reset = 1'b1;
        set_in(k, 1'b0);
        step();
        reset = 1'b0;
    endtask

    // One press, then enough idle cycles for the cooldown to expire.
    task automatic tap(input logic [3:0] k);
        set_in(k, 1'b0);
        step();
        set_in(K_0, 1'b0);
        repeat (CD) step();
    endtask

    // Reference model: tracks times (edge numbers) rather than counters.
    int       m_row, m_col, m_lives, m_t, m_ready, m_respawn;
    bit       m_dead, m_over, m_goal;
    bit [3:0] m_prev;

    task automatic model_reset(input logic [3:0] k);
        m_row = SR; m_col = SC; m_lives = NL;
        m_dead = 0; m_over = 0; m_goal = 0;
        m_t = 0; m_ready = 0; m_respawn = 0;
        m_prev = k;
    endtask

    task automatic model_edge(input logic [3:0] k, input logic h);
        bit [3:0] p;
        p = k & ~m_prev;
        m_prev = k;
        if (m_over) begin
        end else if (m_dead) begin
            if (m_t == m_respawn) begin
                m_dead = 0; m_row = SR; m_col = SC; m_ready = 0;
            end
        end else if (m_goal) begin
            m_goal = 0; m_row = SR; m_col = SC; m_ready = 0;
        end else if (h) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) m_over = 1;
            else begin
                m_dead = 1;
                m_respawn = m_t + RD + 1;
            end
        end else if (p != 0 && m_t >= m_ready) begin
            if (p[3]) begin
                if (m_row > 0) begin
                    m_row = m_row - 1;
                    if (m_row == 0) m_goal = 1;
                end
            end else if (p[2]) m_row = (m_row < 15) ? m_row + 1 : 15;
            else if (p[1]) m_col = (m_col < 15) ? m_col + 1 : 15;
            else m_col = (m_col > 0) ? m_col - 1 : 0;
            m_ready = m_t + CD + 1;
        end
        m_t++;
    endtask

    typedef struct {
        logic [3:0] keys;
        logic       hit;
        bit         vis;
        int         r;
        int         c;
        int         l;
        bit         g;
        bit         ov;
    } vec_t;

    vec_t tbl[18];

    initial begin
        reset = 1'b1;
        set_in(K_0, 1'b0);

        tbl[0]  = '{K_0,       1'b0, 1, 15, 8, 3, 0, 0};
        tbl[1]  = '{K_U,       1'b0, 1, 14, 8, 3, 0, 0};
        tbl[2]  = '{K_U,       1'b0, 1, 14, 8, 3, 0, 0};
        tbl[3]  = '{K_0,       1'b0, 1, 14, 8, 3, 0, 0};
        tbl[4]  = '{K_0,       1'b0, 1, 14, 8, 3, 0, 0};
        tbl[5]  = '{K_L,       1'b0, 1, 14, 8, 3, 0, 0};
        tbl[6]  = '{K_L | K_R, 1'b0, 1, 14, 7, 3, 0, 0};
        tbl[7]  = '{K_0,       1'b1, 0, 0,  0, 2, 0, 0};
        tbl[8]  = '{K_U,       1'b0, 0, 0,  0, 2, 0, 0};
        for (int i = 9; i < 16; i++) tbl[i] = '{K_0, 1'b0, 0, 0, 0, 2, 0, 0};
        tbl[16] = '{K_0,       1'b0, 1, 15, 8, 2, 0, 0};
        tbl[17] = '{K_U,       1'b0, 1, 14, 8, 2, 0, 0};

        // Directed table
        do_reset(K_0);
        expect_state("reset", 1, SR, SC, NL, 0, 0);
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].keys, tbl[i].hit);
            step();
            $display("vec %0d keys=%b hit=%b row=%0d col=%0d lives=%0d", i, tbl[i].keys,
                     tbl[i].hit, row, col, lives);
            expect_state($sformatf("vec%0d", i), tbl[i].vis, tbl[i].r, tbl[i].c, tbl[i].l,
                         tbl[i].g, tbl[i].ov);
        end

        // Held key for 10 cycles gives one move
        do_reset(K_0);
        set_in(K_U, 1'b0);
        repeat (10) step();
        set_in(K_0, 1'b0);
        step();
        $display("held row=%0d", row);
        expect_state("held", 1, 14, SC, NL, 0, 0);

        // Column saturation, saturated press starts cooldown, up beats right
        do_reset(K_0);
        repeat (7) tap(K_L);
        set_in(K_L, 1'b0);
        step();
        $display("sat col=%0d", col);
        expect_state("sat_left", 1, 15, 15, NL, 0, 0);
        set_in(K_0, 1'b0);
        step();
        set_in(K_U, 1'b0);
        step();
        expect_state("sat_cooldown", 1, 15, 15, NL, 0, 0);
        set_in(K_0, 1'b0);
        repeat (3) step();
        set_in(K_U | K_R, 1'b0);
        step();
        $display("prio row=%0d col=%0d", row, col);
        expect_state("prio", 1, 14, 15, NL, 0, 0);
        set_in(K_0, 1'b0);

        // Goal
        do_reset(K_0);
        repeat (14) tap(K_U);
        expect_state("pre_goal", 1, 1, SC, NL, 0, 0);
        set_in(K_U, 1'b0);
        step();
        $display("goal row=%0d goal=%b", row, goal);
        expect_state("goal", 1, 0, SC, NL, 1, 0);
        set_in(K_0, 1'b0);
        step();
        expect_state("goal_respawn", 1, SR, SC, NL, 0, 0);

        // Lives exhausted, keys ignored, reset with key held
        do_reset(K_0);
        for (int i = 0; i < 3; i++) begin
            set_in(K_0, 1'b1);
            step();
            set_in(K_0, 1'b0);
            $display("hit %0d lives=%0d game_over=%b", i, lives, game_over);
            expect_state($sformatf("hit%0d", i), 0, 0, 0, NL - 1 - i, 0, (i == 2));
            if (i < 2) begin
                set_in(K_U, 1'b0);
                repeat (RD) step();
                set_in(K_0, 1'b0);
                expect_state($sformatf("dead_end%0d", i), 0, 0, 0, NL - 1 - i, 0, 0);
                step();
                expect_state($sformatf("respawn%0d", i), 1, SR, SC, NL - 1 - i, 0, 0);
            end
        end
        tap(K_U);
        tap(K_L);
        expect_state("over_keys", 0, 0, 0, 0, 0, 1);
        do_reset(K_U);
        expect_state("over_reset", 1, SR, SC, NL, 0, 0);
        step();
        expect_state("held_through_reset", 1, SR, SC, NL, 0, 0);
        set_in(K_0, 1'b0);

        // Reset during DEAD countdown
        set_in(K_0, 1'b1);
        step();
        set_in(K_0, 1'b0);
        repeat (3) step();
        do_reset(K_0);
        $display("dead_reset lives=%0d", lives);
        expect_state("dead_reset", 1, SR, SC, NL, 0, 0);

        // Randomized run against the model
        do_reset(K_0);
        model_reset(K_0);
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] k;
            logic       h;
            bit         rst;
            int         sel;
            sel = int'($urandom_range(0, 7));
            if (sel <= 2) k = K_U;
            else if (sel == 3) k = 4'($urandom);
            else k = K_0;
            h   = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0) || (m_over && $urandom_range(0, 9) == 0);
            set_in(k, h);
            if (rst) begin
                reset = 1'b1;
                model_reset(k);
            end else begin
                model_edge(k, h);
            end
            step();
            reset = 1'b0;
            $display("rand %0d keys=%b hit=%b rst=%b row=%0d col=%0d lives=%0d", n, k, h, rst,
                     row, col, lives);
            expect_state($sformatf("rand%0d", n), !m_dead && !m_over, m_row, m_col, m_lives,
                         m_goal, m_over);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_mover.md
# frog_mover

Player-position controller for the frogger playfield. Turns the four direction keys into single-step moves of a one-hot frog sprite on the 16×16 grid. Drives `sprite_grid` into the scoring/collision block and consumes that block's `hit` flag to handle death, respawn, lives and game-over. It is the writer of the sprite grid that the scorer reads.

## Interface
- `SPAWN_ROW`, default 15: row index the frog (re)spawns on.
- `SPAWN_COL`, default 8: column bit index the frog (re)spawns on.
- `LIVES`, default 3: lives at reset, range 1..7.
- `COOLDOWN`, default 4: cycles after an accepted move during which new presses are dropped.
- `RESPAWN_DELAY`, default 8: cycles the sprite stays blank after a non-fatal hit.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `key_up`, `key_down`, `key_left`, `key_right`  in  1 each: level inputs, already synchronized, active-high.
- `hit`  in  1: overlap flag from the scorer for the current `sprite_grid`.
- `sprite_grid`  out  [15:0][15:0]: one-hot frog position, or all-zero when blank. Bit 15 of each row is the leftmost column.
- `row`  out  4: current row index.
- `col`  out  4: current column bit index.
- `lives`  out  3: remaining lives.
- `goal`  out  1: one-cycle pulse when the frog reaches row 0.
- `game_over`  out  1: high once lives reach 0; held until reset.

## Operation
- **Press detection.** Keys are registered every cycle. A press is `key & ~key_q`, a rising edge. A held key yields exactly one press. During reset, `key_q` loads the current key levels, so a key held through reset does not produce a press.
- **Move direction.** Forward ("up") decrements the row index; the goal is row 0. Down increments the row. Left increments `col`; right decrements `col`.
- **Edges.** Moves saturate at the grid edges: row 15 ignores down, col 15 ignores left, col 0 ignores right. A saturated press is still consumed and starts the cooldown.
- **Simultaneous presses.** Priority is up > down > left > right. Only one move is taken per cycle; the other presses are discarded.
- **Cooldown.** An accepted move loads the cooldown counter with `COOLDOWN`. The counter decrements each cycle. Presses arriving while it is nonzero are dropped.
- **States.**
  - **PLAY.** Handles presses. If `hit`=1, go to DEAD, or to OVER when `lives`=1. `hit` takes priority over a same-cycle press, which is dropped. A move into row 0 goes to GOAL.
  - **GOAL.** Lasts exactly 1 cycle. The sprite stays shown at row 0 and `goal`=1. Next cycle: row/col reload the spawn position, cooldown clears, state returns to PLAY. `hit` is ignored in GOAL.
  - **DEAD.** `lives` decremented on entry. Sprite blank. A counter loads `RESPAWN_DELAY` and counts to 0, then row/col reload the spawn, cooldown clears, state returns to PLAY. Presses and `hit` are ignored.
  - **OVER.** `lives`=0, sprite blank, `game_over`=1, all inputs ignored until reset.
- **Sprite decode.** `sprite_grid` is decoded from the registered row/col and state. Exactly one bit is set in PLAY/GOAL; all bits are zero in DEAD/OVER.
- **Arithmetic.** Row and column are 4-bit; saturation prevents wrap. `lives` never underflows.

## Timing
- **Reset values:** state PLAY, `row`=`SPAWN_ROW`, `col`=`SPAWN_COL`, sprite bit at (`SPAWN_ROW`,`SPAWN_COL`) set, `lives`=`LIVES`, `goal`=0, `game_over`=0, cooldown=0, respawn counter=0.
- **Move latency.** A key low at edge k-1 and high at edge k is a press at edge k. `row`/`col`/`sprite_grid` show the new position after edge k, a 1-cycle latency.
- **Hit latency.** `hit` sampled high at edge k moves the state to DEAD or OVER after edge k. The sprite is blank and `lives` decremented from that cycle.
- **Respawn timing.** The sprite reappears at spawn `RESPAWN_DELAY`+1 cycles after the hit edge.
- **Goal timing.** `goal` is high for the single cycle the sprite shows row 0. The spawn position shows on the following cycle.
- **Cooldown timing.** After a move accepted at edge k, the next press is accepted no earlier than edge k+`COOLDOWN`+1.
- **Reset mid-operation.** Reset overrides every state, including DEAD countdown and OVER, and restores the reset values on the next edge.

## Test plan
- **Reset and forward move.** Reset, then a single `key_up` pulse → `row` 15→14 one cycle after the press. `sprite_grid[14][8]`=1, all other bits 0.
- **Held key and cooldown.** Hold `key_up` for 10 cycles → exactly one move, `row`=14. Then two presses 2 cycles apart → only the first is accepted.
- **Edge saturation and priority.** At `col`=15, press `key_left` → `col` stays 15. Press up+right in the same cycle → only `row` decrements.
- **Non-fatal hit.** Assert `hit` for 1 cycle in PLAY → `lives` 3→2, sprite all-zero for 9 cycles, then at (15,8). A press during DEAD has no effect.
- **Lives exhausted.** Three hits with respawns between them → `lives`=0, `game_over`=1, sprite blank. Keys are ignored until reset, which restores `lives`=3.
- **Goal.** 15 spaced up presses → `row`=0 with `goal`=1 for 1 cycle, then `row`=15, `col`=8, `lives` unchanged.
